ring_counter: RTL and testbench

RING_COUNTER -- requirements
Module: ring_counter

---
 rtl/ring_counter_pkg.sv | 12 +
 rtl/onehot_check.sv | 15 +
 rtl/ring_counter.sv | 45 ++++
 tb/tb_ring_counter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and the reset-pattern helper for the ring counter.
package ring_counter_pkg;
  localparam int RC_DEFAULT_WIDTH = 4;

  // Only bit (w-1) set, returned at the widest legal width; callers slice it.
  function automatic logic [31:0] rc_reset_pattern(input int w);
    logic [31:0] p;
    p        = '0;
    p[w-1]   = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/onehot_check.sv
// Flags whether a vector has exactly one bit set.
module onehot_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             is_onehot
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_low_clr;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign w_low_clr = i_vec & (i_vec - ONE);
  assign is_onehot = (i_vec != '0) && (w_low_clr == '0);
endmodule

// File: rtl/ring_counter.sv
// One-hot ring counter with selectable direction and optional recovery from illegal states.
module ring_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH        = RC_DEFAULT_WIDTH,
  parameter bit SHIFT_LEFT   = 1'b1,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);
  localparam logic [31:0]      RST_FULL = rc_reset_pattern(WIDTH);
  localparam logic [WIDTH-1:0] RST_PAT  = RST_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_rot;
  logic             w_onehot;

  generate
    if (SHIFT_LEFT) begin : g_left
      assign w_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    end else begin : g_right
      assign w_rot = {r_q[0], r_q[WIDTH-1:1]};
    end

    if (SELF_CORRECT) begin : g_chk
      onehot_check #(.WIDTH(WIDTH)) u_chk (
        .i_vec     (r_q),
        .is_onehot (w_onehot)
      );
    end else begin : g_nochk
      // Pure rotation: every state is treated as legal.
      assign w_onehot = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_q <= RST_PAT;
    else if (!w_onehot) r_q <= RST_PAT;
    else                r_q <= w_rot;
  end

  assign q = r_q;
endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench: expected values queued per clock edge, popped and compared after it.
module tb_ring_counter;
  typedef struct {
    string      tag;
    int         which;
    logic [7:0] exp;
  } sb_ent_t;

  logic       clk;
  logic       rst;
  logic [3:0] q_def, q_fc, q_nc;
  logic [7:0] q_w8;

  int n_chk  = 0;
  int n_pass = 0;
  bit seen_rst = 0;
  sb_ent_t sb[$];

  ring_counter dut (.clk(clk), .rst(rst), .q(q_def));
  ring_counter #(.WIDTH(4), .SHIFT_LEFT(1), .SELF_CORRECT(1)) dut_fc (.clk(clk), .rst(rst), .q(q_fc));
  ring_counter #(.WIDTH(4), .SHIFT_LEFT(1), .SELF_CORRECT(0)) dut_nc (.clk(clk), .rst(rst), .q(q_nc));
  ring_counter #(.WIDTH(8), .SHIFT_LEFT(0), .SELF_CORRECT(1)) dut_w8 (.clk(clk), .rst(rst), .q(q_w8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [7:0] sample(input int which);
    case (which)
      0:       return {4'b0, q_def};
      1:       return {4'b0, q_fc};
      2:       return {4'b0, q_nc};
      default: return q_w8;
    endcase
  endfunction

  task automatic push(input string tag, input int which, input logic [7:0] exp);
    sb_ent_t e;
    e.tag = tag; e.which = which; e.exp = exp;
    sb.push_back(e);
  endtask

  // Advance one clock edge, then drain the scoreboard against the DUT outputs.
  task automatic tick();
    sb_ent_t e;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, sample(e.which), e.exp);
    end
  endtask

  // Every cycle after the first reset the unforced default counter must be one-hot.
  always @(negedge clk) begin
    if (rst) seen_rst = 1;
    if (seen_rst) chk("onehot", {7'b0, $onehot(q_def)}, 8'd1);
  end

  logic [3:0] seq4 [4];

  initial begin
    seq4[0] = 4'b0001; seq4[1] = 4'b0010; seq4[2] = 4'b0100; seq4[3] = 4'b1000;
    rst = 1'b1;
    #2;
    chk("rst_def", {4'b0, q_def}, 8'h08);
    chk("rst_w8",  q_w8,          8'h80);
    #8 rst = 1'b0;                         // t=10

    // Free run from reset: two full periods of the 4-wide and one of the 8-wide.
    for (int i = 0; i < 8; i++) begin
      push($sformatf("run_def%0d", i), 0, {4'b0, seq4[i % 4]});
      push($sformatf("run_nc%0d", i),  2, {4'b0, seq4[i % 4]});
      push($sformatf("run_w8_%0d", i), 3, 8'h80 >> ((i + 1) % 8));
      tick();
    end

    // Reset between edges while q=0100.
    for (int i = 0; i < 3; i++) begin
      push($sformatf("pre_mid%0d", i), 0, {4'b0, seq4[i]});
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_def", {4'b0, q_def}, 8'h08);
    chk("mid_rst_w8",  q_w8,          8'h80);
    #1 rst = 1'b0;
    push("post_mid_def", 0, 8'h01);
    push("post_mid_w8",  3, 8'h40);
    tick();

    // Reset held across three edges.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("hold_def%0d", i), 0, 8'h08);
      push($sformatf("hold_w8_%0d", i), 3, 8'h80);
      tick();
    end
    rst = 1'b0;
    push("post_hold_def", 0, 8'h01);
    push("post_hold_w8",  3, 8'h40);
    tick();

    // Illegal all-zero state: recovered with self-correct, stuck without.
    force dut_fc.r_q = 4'b0000;
    force dut_nc.r_q = 4'b0000;
    #1;
    release dut_fc.r_q;
    release dut_nc.r_q;
    push("zero_fc", 1, 8'h08);
    push("zero_nc", 2, 8'h00);
    tick();
    push("zero_nc2", 2, 8'h00);
    push("zero_fc2", 1, 8'h01);
    tick();

    // Illegal multi-bit state.
    force dut_fc.r_q = 4'b0110;
    #1;
    release dut_fc.r_q;
    push("multi_fc", 1, 8'h08);
    tick();
    push("multi_fc2", 1, 8'h01);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
